// File: rtl/ncc_window_feeder_pkg.sv
// Shared types for the NCC window feeder: log2 pixel format, chain length and FSM states.
package ncc_window_feeder_pkg;

  localparam int unsigned PE_COUNT = 16;

  // {sign, int[4:0], frac[-1:-27]}
  typedef bit [5:-27] log_pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream
  } feeder_state_e;

endpackage

// File: rtl/ncc_window_feeder_if.sv
// Pixel stream in, PE-chain drive and frame status out.
interface ncc_window_feeder_if #(
  parameter int unsigned PIX_W = 8
);
  import ncc_window_feeder_pkg::*;

  logic             start;
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;
  log_pixel_t       win_pixel;
  logic             load_win_reg;
  logic             load_acc_sum_reg;
  logic             row_done;
  logic             frame_done;
  logic             busy;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, win_pixel, load_win_reg, load_acc_sum_reg, row_done, frame_done, busy
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, win_pixel, load_win_reg, load_acc_sum_reg, row_done, frame_done, busy
  );

endinterface

// File: rtl/ncc_window_feeder_pixel_to_log2.sv
// Unsigned pixel to log2 format: int = leading-one index, frac = bits below it, left-aligned.
module ncc_window_feeder_pixel_to_log2
  import ncc_window_feeder_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [PIX_W-1:0] pixel,
  output log_pixel_t       log_pixel
);

  logic [4:0]  lead;
  logic [26:0] mant;

  always_comb begin
    lead = '0;
    // Later (higher) set bits override, so this is a priority leading-one encoder.
    for (int i = 0; i < PIX_W; i++) begin
      if (pixel[i]) lead = 5'(i);
    end
    mant      = 27'(pixel) & ~(27'(1) << lead);
    log_pixel = {1'b0, lead, mant << (5'd27 - lead)};
  end

endmodule

// File: rtl/ncc_window_feeder.sv
// Feeds the 16-PE NCC chain row by row: prime PE_COUNT pixels, then stream with accumulation.
module ncc_window_feeder #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned PE_COUNT = ncc_window_feeder_pkg::PE_COUNT,
  parameter int unsigned WIN_W    = 640,
  parameter int unsigned WIN_H    = 16
) (
  input logic                clk,
  input logic                rst,
  ncc_window_feeder_if.slave bus
);
  import ncc_window_feeder_pkg::*;

  localparam int unsigned COL_W = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int unsigned ROW_W = (WIN_H > 1) ? $clog2(WIN_H) : 1;

  feeder_state_e    state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             busy_q, busy_d;
  logic             accept, last_col, last_row;
  log_pixel_t       conv, pix_q;
  logic             lwr_q, lacc_q, rd_q, fd_q;

  ncc_window_feeder_pixel_to_log2 #(
    .PIX_W (PIX_W)
  ) u_log2 (
    .pixel     (bus.in_data),
    .log_pixel (conv)
  );

  assign bus.in_ready = (state_q == StFill) || (state_q == StStream);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_col     = (col_q == COL_W'(WIN_W - 1));
  assign last_row     = (row_q == ROW_W'(WIN_H - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    busy_d  = busy_q;
    if (fd_q) busy_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // busy_q is still high during the frame_done cycle, which blocks an immediate restart.
        if (bus.start && !busy_q) begin
          state_d = StFill;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StFill, StStream: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = StIdle;
              row_d   = '0;
            end else begin
              state_d = StFill;
              row_d   = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
            if (col_q == COL_W'(PE_COUNT - 1)) state_d = StStream;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      pix_q   <= '0;
      lwr_q   <= 1'b0;
      lacc_q  <= 1'b0;
      rd_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      lwr_q   <= accept;
      lacc_q  <= accept && (col_q >= COL_W'(PE_COUNT));
      rd_q    <= accept && last_col;
      fd_q    <= accept && last_col && last_row;
      if (accept) pix_q <= conv;
    end
  end

  assign bus.win_pixel        = pix_q;
  assign bus.load_win_reg     = lwr_q;
  assign bus.load_acc_sum_reg = lacc_q;
  assign bus.row_done         = rd_q;
  assign bus.frame_done       = fd_q;
  assign bus.busy             = busy_q;

endmodule
